// File: rtl/pic_arbiter.sv
// Priority interrupt controller: per-source config table, pending capture, three-state grant FSM.
// Define PIC_EDGE_DETECT_EN for rising-edge capture of irq_src; default build captures on level.
module pic_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] irq_src,
   input  logic       cfg_we,
   input  logic [2:0] cfg_addr,
   input  logic [7:0] cfg_wdata,
   output logic [7:0] cfg_rdata,
   input  logic [2:0] curr_pri,
   input  logic       int_ack,
   output logic [7:0] pic_out,
   output logic [7:0] pend_out
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARB  = 2'd1;
   localparam logic [1:0] ST_REQ  = 2'd2;

   logic [1:0] state_r;
   logic [1:0] state_nxt_s;
   logic [7:0] pending_r;
   logic [7:0] enable_r;
   logic [2:0] prio_r [8];
   logic [3:0] vec_r [8];
   logic [7:0] elig_s;
   logic       elig_any_r;
   logic [7:0] set_s;
   logic [7:0] clr_s;
   logic       win_found_s;
   logic [2:0] win_idx_s;
   logic [2:0] win_pri_s;
   logic [3:0] win_vec_s;
   logic [2:0] win_idx_r;

`ifdef PIC_EDGE_DETECT_EN
   logic [7:0] irq_prev_r;

   // History also loads during reset so a line held high across reset is not seen as a new edge.
   always_ff @(posedge clk) begin
      irq_prev_r <= irq_src;
   end

   assign set_s = irq_src & ~irq_prev_r;
`else
   assign set_s = irq_src;
`endif

   assign cfg_rdata = {enable_r[cfg_addr], prio_r[cfg_addr], vec_r[cfg_addr]};
   assign pend_out  = pending_r;

   // Configuration table: reset maps vector i to source i with everything disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         enable_r <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            prio_r[i] <= 3'd0;
            vec_r[i]  <= 4'(i);
         end
      end else if (cfg_we) begin
         enable_r[cfg_addr] <= cfg_wdata[7];
         prio_r[cfg_addr]   <= cfg_wdata[6:4];
         vec_r[cfg_addr]    <= cfg_wdata[3:0];
      end
   end

   // Eligibility per source; priority 0 can never exceed curr_pri.
   always_comb begin
      elig_s = 8'h00;
      for (int i = 0; i < 8; i++) begin
         elig_s[i] = pending_r[i] & enable_r[i] & (prio_r[i] > curr_pri);
      end
   end

   // Winner search: strict compare while walking upward keeps ties on the lowest index.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = 3'd0;
      win_pri_s   = 3'd0;
      win_vec_s   = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (elig_s[i] && (prio_r[i] > win_pri_s)) begin
            win_found_s = 1'b1;
            win_idx_s   = 3'(i);
            win_pri_s   = prio_r[i];
            win_vec_s   = vec_r[i];
         end else begin
         end
      end
   end

   // Pending clear mask for the acknowledged winner.
   always_comb begin
      clr_s = 8'h00;
      if ((state_r == ST_REQ) && int_ack) begin
         clr_s[win_idx_r] = 1'b1;
      end else begin
         clr_s = 8'h00;
      end
   end

   // Next-state logic for the grant FSM.
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: state_nxt_s = elig_any_r  ? ST_ARB  : ST_IDLE;
         ST_ARB:  state_nxt_s = win_found_s ? ST_REQ  : ST_IDLE;
         ST_REQ:  state_nxt_s = int_ack     ? ST_IDLE : ST_REQ;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state, pending capture (set beats ack-clear) and the registered grant word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         pending_r  <= 8'h00;
         elig_any_r <= 1'b0;
         win_idx_r  <= 3'd0;
         pic_out    <= 8'h00;
      end else begin
         state_r    <= state_nxt_s;
         pending_r  <= (pending_r & ~clr_s) | set_s;
         elig_any_r <= |elig_s;
         case (state_r)
            ST_ARB: begin
               if (win_found_s) begin
                  win_idx_r <= win_idx_s;
                  pic_out   <= {1'b1, win_pri_s, win_vec_s};
               end else begin
                  pic_out   <= 8'h00;
               end
            end
            ST_REQ: begin
               if (int_ack) begin
                  pic_out <= 8'h00;
               end
            end
            default: pic_out <= 8'h00;
         endcase
      end
   end

endmodule

// File: doc/pic_arbiter.md
PIC_ARBITER -- requirements
Module: pic_arbiter

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 irq_src  input  8  device interrupt lines, bit i = source i.
REQ-004 cfg_we  input  1  configuration write strobe, one cycle.
REQ-005 cfg_addr  input  3  source index for the configuration write and readback.
REQ-006 cfg_wdata  input  8  [7] enable, [6:4] priority, [3:0] vector.
REQ-007 cfg_rdata  output  8  combinational readback of the entry at cfg_addr, same format.
REQ-008 curr_pri  input  3  current CPU priority from PSW.
REQ-009 int_ack  input  1  CPU entry-routine acknowledge, one cycle.
REQ-010 pic_out  output  8  [7] valid, [6:4] granted priority, [3:0] granted vector; feeds CPU pic_in.
REQ-011 pend_out  output  8  registered pending bits, for debug and status.

Function
REQ-012 Each source SHALL hold a config entry: enable, 3-bit priority, 4-bit vector.
REQ-013 A cfg_we write SHALL update entry cfg_addr on the next edge; the new values are visible on cfg_rdata after that edge.
REQ-014 Source i is eligible when pending[i]=1, enable[i]=1 and priority[i] > curr_pri (unsigned); priority 0 is never eligible.
REQ-015 The FSM SHALL have the states IDLE, ARB and REQ.
REQ-016 IDLE: if any source is eligible, the FSM SHALL go to ARB; otherwise it stays in IDLE.
REQ-017 ARB: the winner is the eligible source with the highest priority; ties go to the lowest index.
REQ-018 ARB: the winner index, priority and vector SHALL be registered and pic_out[7] set, with the FSM going to REQ.
REQ-019 ARB: if no source is still eligible (curr_pri rose, or the source was disabled), the FSM SHALL return to IDLE with pic_out[7]=0.
REQ-020 REQ: pic_out SHALL stay constant until int_ack; later higher-priority arrivals, curr_pri changes and cfg writes do not alter it.
REQ-021 REQ with int_ack=1: pending[winner] SHALL clear, pic_out SHALL become 8'h00, and the FSM SHALL go to IDLE, all on that edge.
REQ-022 int_ack outside REQ SHALL be ignored.
REQ-023 A new capture event on the winner source in the same cycle as its int_ack SHALL leave pending set (set wins).
REQ-024 Latency: for an eligible source with the FSM idle, pic_out[7] rises 3 edges after the edge that sets pending.
REQ-025 pic_out[6:0] SHALL be 0 whenever pic_out[7]=0.
REQ-026 Disabling a source SHALL NOT clear its pending bit; re-enabling it makes it eligible again.

Reset
REQ-027 While rst=1 on an edge: state=IDLE, pending=0, pic_out=8'h00, every enable=0, every priority=0, vector[i]=i.
REQ-028 Reset SHALL take priority over cfg_we, int_ack and captures in the same cycle, including mid-REQ.

Configuration
REQ-029 Macro PIC_EDGE_DETECT_EN defined: a registered copy of irq_src is kept, and pending[i] is set on a 0->1 transition of irq_src[i].
REQ-030 Macro PIC_EDGE_DETECT_EN absent: pending[i] is set every edge irq_src[i]=1 (level mode), and no irq_src history register exists.
REQ-031 In level mode an ack of a still-high line re-pends it on the next edge; that is intended behaviour.

Verification
REQ-032 After reset: pic_out=00, pend_out=00, cfg_rdata at addr 5 = 8'h05.
REQ-033 Cfg src2 = 8'hB7 (enable, pri 3, vec 7), curr_pri=1, pulse irq_src[2] -> pic_out=8'hB7 exactly 3 edges later, stable until int_ack, then 00 and pend_out[2]=0.
REQ-034 Src1 at pri 4 vec 9 and src6 at pri 4 vec 3 pend together, curr_pri=0 -> pic_out=8'hC9; after ack -> 8'hC3.
REQ-035 Src3 at pri 2 with curr_pri=2 -> no request. Lower curr_pri to 1 -> pic_out[7]=1 with pri field 2.
REQ-036 While in REQ for src0, pend src7 at a higher priority -> pic_out unchanged until ack; src7 is granted next.
REQ-037 Assert rst mid-REQ -> next edge pic_out=00 and all config at reset values. Edge mode: a held-high irq_src does not re-pend; level mode: it does.
